// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB first over WIDTH bits.
// start/busy/done handshake; result and cout held until the next completion.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW_RAW = $clog2(WIDTH + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic [WIDTH-1:0] sh_s_nx;
    logic             carry_reg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_sum;
    logic             fa_carry;

    fulladder u_fa (
        .a     (sh_a[0]),
        .b     (sh_b[0]),
        .c     (carry_reg),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_one
            assign sh_s_nx = fa_sum;
        end else begin : g_multi
            assign sh_s_nx = {fa_sum, sh_s[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt == LAST);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a      <= '0;
            sh_b      <= '0;
            sh_s      <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            cout      <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                sh_a      <= op_a;
                sh_b      <= op_b;
                carry_reg <= cin;
                cnt       <= '0;
            end
        end else if (state == RUN) begin
            sh_a      <= sh_a >> 1;
            sh_b      <= sh_b >> 1;
            sh_s      <= sh_s_nx;
            carry_reg <= fa_carry;
            cnt       <= cnt + CW'(1);
            if (last_bit) begin
                result <= sh_s_nx;
                cout   <= fa_carry;
            end
        end
    end

endmodule
